// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two skid FIFOs (EXE, MEM) feeding one registered
// broadcast per cycle, oldest-first with a starvation guard, stall and flush.
module cdb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        flush,
  input  logic        cdb_stall,
  input  logic        exe_valid,
  output logic        exe_ready,
  input  logic [5:0]  exe_map,
  input  logic [4:0]  exe_reg,
  input  logic [31:0] exe_val,
  input  logic [31:0] exe_instr_num,
  input  logic        exe_regwr,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [5:0]  mem_map,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_val,
  input  logic [31:0] mem_instr_num,
  input  logic        mem_regwr,
  output logic        cdb_valid,
  output logic [5:0]  cdb_map,
  output logic [4:0]  cdb_reg,
  output logic [31:0] cdb_val,
  output logic [31:0] cdb_instr_num,
  output logic        cdb_regwr,
  output logic        cdb_src
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [5:0]  map;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] num;
    logic        regwr;
  } entry_t;

  // Index 0 is EXE, index 1 is MEM, matching the cdb_src encoding.
  entry_t             fifo_q    [2][DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q  [2];
  logic [PTR_W-1:0]   wr_ptr_d  [2];
  logic [PTR_W-1:0]   rd_ptr_q  [2];
  logic [PTR_W-1:0]   rd_ptr_d  [2];
  logic [CNT_W-1:0]   count_q   [2];
  logic [CNT_W-1:0]   count_d   [2];
  logic [STV_W-1:0]   starve_q  [2];
  logic [STV_W-1:0]   starve_d  [2];
  logic               ready_q;
  logic               ready_d;
  entry_t             cdb_q;
  entry_t             cdb_d;
  logic               cdb_valid_q;
  logic               cdb_valid_d;
  logic               cdb_src_q;
  logic               cdb_src_d;

  entry_t             push_data [2];
  logic               push_req  [2];
  logic               ready     [2];
  logic               push      [2];
  logic               pop       [2];
  logic               nonempty  [2];
  entry_t             head      [2];
  logic               grant;
  logic               do_pop;
  logic               exe_older;

  assign push_data[0] = '{map: exe_map, rd: exe_reg, val: exe_val, num: exe_instr_num, regwr: exe_regwr};
  assign push_data[1] = '{map: mem_map, rd: mem_reg, val: mem_val, num: mem_instr_num, regwr: mem_regwr};
  assign push_req[0]  = exe_valid;
  assign push_req[1]  = mem_valid;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ready_d     = 1'b1;
    cdb_d       = cdb_q;
    cdb_valid_d = cdb_valid_q;
    cdb_src_d   = cdb_src_q;
    grant       = 1'b0;

    for (int s = 0; s < 2; s++) begin
      ready[s]    = ready_q && (count_q[s] < CNT_W'(DEPTH));
      push[s]     = push_req[s] && ready[s] && !flush;
      nonempty[s] = (count_q[s] != '0);
      head[s]     = fifo_q[s][rd_ptr_q[s]];
    end

    // Wrap-safe age compare on sequence numbers; ties go to MEM.
    exe_older = $signed(head[0].num - head[1].num) < 0;

    if (nonempty[0] && nonempty[1]) begin
      if (starve_q[0] == STV_W'(STARVE_LIMIT))      grant = 1'b0;
      else if (starve_q[1] == STV_W'(STARVE_LIMIT)) grant = 1'b1;
      else                                          grant = !exe_older;
    end else begin
      grant = !nonempty[0];
    end

    do_pop = !cdb_stall && !flush && (nonempty[0] || nonempty[1]);

    for (int s = 0; s < 2; s++) begin
      pop[s]      = do_pop && (grant == s[0]);
      wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop[s]);
      count_d[s]  = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      starve_d[s] = starve_q[s];
      if (!cdb_stall) begin
        if (!nonempty[s] || pop[s])
          starve_d[s] = '0;
        else if (starve_q[s] != STV_W'(STARVE_LIMIT))
          starve_d[s] = starve_q[s] + 1'b1;
      end
      if (flush) begin
        wr_ptr_d[s] = '0;
        rd_ptr_d[s] = '0;
        count_d[s]  = '0;
        starve_d[s] = '0;
      end
    end

    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (!cdb_stall) begin
      cdb_valid_d = do_pop;
      if (do_pop) begin
        cdb_d     = head[grant];
        cdb_src_d = grant;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
        starve_q[s] <= '0;
      end
      ready_q     <= 1'b0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        count_q[s]  <= count_d[s];
        starve_q[s] <= starve_d[s];
      end
      ready_q     <= ready_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone decides which slots are live.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) fifo_q[s][wr_ptr_q[s]] <= push_data[s];
    end
  end

  assign exe_ready     = ready[0];
  assign mem_ready     = ready[1];
  assign cdb_valid     = cdb_valid_q;
  assign cdb_map       = cdb_q.map;
  assign cdb_reg       = cdb_q.rd;
  assign cdb_val       = cdb_q.val;
  assign cdb_instr_num = cdb_q.num;
  assign cdb_regwr     = cdb_q.regwr;
  assign cdb_src       = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completion broadcasts from the EXE and MEM units onto a single registered common data bus (CDB).
- The CDB feeds the ROB and the ID/issue wakeup logic, so they see at most one broadcast (map, reg, value, instr_num) per cycle.
- Each source has a small skid FIFO with a valid/ready handshake.
- Arbitration is age-based with a starvation guard. The block honours ROB stall and pipeline flush.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a source is force-granted; >= 1.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all pending and output broadcasts.
- cdb_stall  in  1  ROB cannot accept; hold output.
- exe_valid  in  1  EXE broadcast offered.
- exe_ready  out  1  EXE FIFO can accept.
- exe_map  in  6  physical map tag.
- exe_reg  in  5  architectural destination.
- exe_val  in  32  result value.
- exe_instr_num  in  32  instruction sequence number.
- exe_regwr  in  1  writes a register.
- mem_valid, mem_ready, mem_map, mem_reg, mem_val, mem_instr_num, mem_regwr: same widths and meanings, for MEM.
- cdb_valid  out  1  broadcast valid.
- cdb_map  out  6.
- cdb_reg  out  5.
- cdb_val  out  32.
- cdb_instr_num  out  32.
- cdb_regwr  out  1.
- cdb_src  out  1  0 = EXE, 1 = MEM.

Behaviour:
- Reset (RESET low, async):
  - FIFOs empty, starvation counters 0.
  - All cdb_* outputs 0.
  - exe_ready = mem_ready = 0 while RESET is low; they go to 1 on the first cycle after release.
- Push:
  - x_ready = (count_x < DEPTH), derived from registered count only; it does not credit a same-cycle pop.
  - Entry written on an edge where x_valid && x_ready && !flush.
  - Offering valid while ready=0 is legal; the source holds its data until accepted.
- FIFOs:
  - Circular, wrap-around read/write pointers with a count of 0..DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- Pop/arbitration (each edge with !cdb_stall && !flush):
  - Candidates are the non-empty FIFO heads.
  - One candidate: it wins.
  - Both candidates:
    - If a source's starve counter == STARVE_LIMIT, that source wins.
    - Otherwise the older instr_num wins, where "older" means $signed(a - b) < 0 (wrap-safe).
    - Equal instr_num: MEM wins.
  - Winner's head is popped and loaded into the output registers; cdb_valid=1, cdb_src set.
  - Loser's starve counter increments (saturating at STARVE_LIMIT); winner's counter clears.
  - A source that is empty has its counter cleared.
  - No candidates: cdb_valid=0 next cycle; payload registers hold their previous values (don't-care).
- Stall: with cdb_stall=1 there is no pop; all cdb_* and counters hold. Pushes continue until the FIFOs are full.
- Latency:
  - A push at edge N appears on the CDB after edge N+1 at the earliest.
  - Throughput is one broadcast per unstalled cycle.
- Flush:
  - On an edge with flush=1: both FIFOs emptied, counters cleared, cdb_valid=0.
  - Same-cycle pushes are dropped.
  - flush has priority over cdb_stall.
- Invariants:
  - The CDB never carries a duplicate or lost entry.
  - Per-source order is preserved (FIFO).

Test Plan:
1. Reset: RESET low mid-operation with 2 entries queued -> immediately cdb_valid=0, exe_ready=mem_ready=0; after release ready=1 and no stale entry is broadcast.
2. Single source: EXE pushes instr_num 5,6,7 on consecutive cycles -> CDB shows 5,6,7 on consecutive cycles with cdb_src=0; first appears 2 edges after the first push.
3. Age arbitration: EXE instr_num 10 and MEM instr_num 9 pushed together -> CDB shows 9 (MEM), then 10. With EXE 0x00000001 vs MEM 0xFFFFFFFF, the MEM entry wins (wrap).
4. Starvation: MEM continuously offers older entries while EXE holds one entry -> EXE is granted on the 5th arbitration (STARVE_LIMIT=4); its counter then clears.
5. Backpressure: cdb_stall=1 for 4 cycles while EXE pushes -> exe_ready drops after 2 accepts; cdb_* held constant; on release, entries drain in order with none lost.
6. Flush: flush=1 with both FIFOs full and a simultaneous push -> next cycle cdb_valid=0, both ready=1; the dropped push never appears on the CDB.
